// File: rtl/co_code_serializer.sv
`default_nettype none
// ============================================================================
// Module      : co_code_serializer
// Description : Serial transmitter for the CO alarm code. On start it sends a
//               fixed CODE_WIDTH-bit code MSB first on x_out. Each bit is held
//               for BIT_CYCLES clocks. The frame is repeated REPS times, with
//               GAP zero bit-times between frames. This module drives the input
//               of the CO pattern detector.
// Ports       : CLK        - rising-edge clock
//               RST        - synchronous active-high reset
//               start      - send request, sampled only while idle
//               abort      - drop any transfer at the next edge
//               x_out      - registered serial code line
//               busy       - high while sending a frame or a gap
//               frame_done - one-cycle pulse after each completed frame
//               done       - one-cycle pulse after the final frame
// Revision    : 1.0 - initial release
// ============================================================================
module co_code_serializer #(
    parameter int                    CODE_WIDTH = 12,
    parameter logic [CODE_WIDTH-1:0] CODE       = 12'b101010010011,
    parameter int                    BIT_CYCLES = 1,
    parameter int                    REPS       = 1,
    parameter int                    GAP        = 0
) (
    input  logic CLK,
    input  logic RST,
    input  logic start,
    input  logic abort,
    output logic x_out,
    output logic busy,
    output logic frame_done,
    output logic done
);

    localparam int IW   = $clog2(CODE_WIDTH);
    localparam int CY_W = $clog2(BIT_CYCLES) + 1;

    localparam logic [IW-1:0]   c_IDX_MSB  = IW'(CODE_WIDTH - 1);
    localparam logic [CY_W-1:0] c_CYC_LAST = CY_W'(BIT_CYCLES - 1);
    localparam logic [7:0]      c_REPS     = 8'(REPS);
    // When GAP is 0 this value is never compared; the gap state is unreachable.
    localparam logic [7:0]      c_GAP_LAST = 8'(GAP - 1);
    localparam logic            c_HAS_GAP  = (GAP > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [CY_W-1:0] r_cyc;
    logic [7:0]      r_gap;
    logic [7:0]      r_frm;

    logic            w_bit_end;
    logic [7:0]      w_frm_next;
    logic            w_last_frame;
    logic [IW-1:0]   w_idx_dec;

    assign w_bit_end    = (r_cyc == c_CYC_LAST);
    assign w_frm_next   = r_frm + 8'd1;
    assign w_last_frame = (w_frm_next == c_REPS);
    assign w_idx_dec    = r_idx - IW'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cyc      <= '0;
            r_gap      <= '0;
            r_frm      <= '0;
            x_out      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Pulses are one cycle wide unless re-asserted below.
            frame_done <= 1'b0;
            done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    x_out <= 1'b0;
                    busy  <= 1'b0;
                    // abort takes priority over a simultaneous start.
                    if (start && !abort) begin
                        r_state <= S_SEND;
                        r_idx   <= c_IDX_MSB;
                        r_cyc   <= '0;
                        r_frm   <= '0;
                        x_out   <= CODE[c_IDX_MSB];
                        busy    <= 1'b1;
                    end
                end

                S_SEND: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        x_out   <= 1'b0;
                        busy    <= 1'b0;
                    end else if (!w_bit_end) begin
                        r_cyc <= r_cyc + CY_W'(1);
                    end else begin
                        r_cyc <= '0;
                        if (r_idx != '0) begin
                            r_idx <= w_idx_dec;
                            x_out <= CODE[w_idx_dec];
                        end else begin
                            // Last bit of the frame has just been held.
                            frame_done <= 1'b1;
                            r_frm      <= w_frm_next;
                            if (w_last_frame) begin
                                r_state <= S_IDLE;
                                x_out   <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else if (c_HAS_GAP) begin
                                r_state <= S_GAP;
                                r_gap   <= '0;
                                x_out   <= 1'b0;
                            end else begin
                                // Back-to-back frames: next MSB follows directly.
                                r_idx <= c_IDX_MSB;
                                x_out <= CODE[c_IDX_MSB];
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        x_out   <= 1'b0;
                        busy    <= 1'b0;
                    end else if (!w_bit_end) begin
                        r_cyc <= r_cyc + CY_W'(1);
                    end else begin
                        r_cyc <= '0;
                        if (r_gap == c_GAP_LAST) begin
                            r_state <= S_SEND;
                            r_idx   <= c_IDX_MSB;
                            x_out   <= CODE[c_IDX_MSB];
                        end else begin
                            r_gap <= r_gap + 8'd1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    x_out   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/co_code_serializer.md
Name: co_code_serializer

Overview:
- Serial transmitter for the smart-home CO alarm code.
- On a start request it shifts a fixed 12-bit code onto a single serial line, MSB first, one bit per BIT_CYCLES clocks.
- Repeats the frame REPS times, with an optional zero-filled gap between frames.
- Drives the input of the CO pattern detector; it is the sending end of that serial link. Sensor/test logic uses it to raise the alarm pattern.

Parameters:
- CODE_WIDTH, 12, number of code bits per frame (legal range 2..16).
- CODE, 12'b101010010011, code word sent MSB first; bit CODE_WIDTH-1 goes out first.
- BIT_CYCLES, 1, clock cycles each serial bit is held (legal >=1).
- REPS, 1, frames sent per start (legal 1..255).
- GAP, 0, idle bit-times of 0 inserted between consecutive frames (legal 0..255); no gap after the last frame.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- start  input  1  request to send; sampled only in IDLE.
- abort  input  1  stops any transfer at the next edge.
- x_out  output  1  serial code line, registered.
- busy  output  1  high while in SEND or GAP.
- frame_done  output  1  one-cycle pulse after each completed frame.
- done  output  1  one-cycle pulse after the final frame.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - RST high at a rising edge forces IDLE and clears all counters.
  - x_out=0, busy=0, frame_done=0, done=0 from that edge on.
  - RST overrides start and abort, including mid-frame.
- All outputs are registered. No combinational path from start or abort to any output.
- States: IDLE, SEND, GAP.
- IDLE:
  - x_out=0, busy=0.
  - start=1 and abort=0 at edge k -> SEND, busy=1, x_out=CODE[CODE_WIDTH-1] from edge k.
  - Bit index = CODE_WIDTH-1, cycle count = 0, frame count = 0.
- SEND:
  - Each bit is held exactly BIT_CYCLES cycles; the index then decrements and x_out shows the next bit.
  - Last bit (index 0) completes:
    - frame_done pulses 1 cycle and the frame count increments.
    - Frames remaining and GAP>0 -> GAP, x_out=0.
    - Frames remaining and GAP=0 -> stay in SEND, reload index, x_out=CODE[MSB] on the very next cycle (back-to-back frames, no idle bit).
    - Final frame -> IDLE with x_out=0, busy=0; done and frame_done both high for that one cycle.
- GAP:
  - x_out=0 for GAP*BIT_CYCLES cycles, busy=1.
  - Then SEND with index reloaded and x_out=CODE[MSB].
- Latency: start at edge k with BIT_CYCLES=1, REPS=1 ->
  - x_out carries code bits in cycles k..k+11;
  - busy falls and done pulses at edge k+12.
  - Total busy time = REPS*CODE_WIDTH*BIT_CYCLES + (REPS-1)*GAP*BIT_CYCLES cycles.
- start while busy: ignored, no queuing.
- start held high continuously: a new transfer begins at the edge after done, because start is sampled in IDLE. A one-cycle IDLE with x_out=0 separates the transfers.
- abort=1 in SEND or GAP:
  - next edge -> IDLE, x_out=0, busy=0.
  - No frame_done or done pulse, even if abort coincides with the last bit ending.
- abort=1 in IDLE: stays IDLE. abort beats a simultaneous start.
- Counter widths:
  - bit index: clog2(CODE_WIDTH)
  - cycle counter: clog2(BIT_CYCLES)+1
  - gap counter and frame counter: 8 bits each.
  - No wrap-around is reachable within the legal parameter ranges.

Test Plan:
- Reset then start pulse, defaults -> x_out = 1,0,1,0,1,0,0,1,0,0,1,1 in the 12 cycles after start; busy high 12 cycles; done and frame_done pulse together at cycle 12. A behavioural CO-detector model fed from x_out asserts its output in exactly one cycle.
- REPS=3, GAP=2, BIT_CYCLES=1 -> three frames separated by exactly two 0 bits; frame_done pulses at cycles 12, 26, 40; done pulses only at cycle 40; busy high 40 cycles.
- REPS=2, GAP=0 -> 24 contiguous code bits; detector model asserts twice, 12 cycles apart; frame_done at cycles 12 and 24.
- BIT_CYCLES=3, REPS=1 -> each bit held 3 cycles, 36 busy cycles; done at cycle 36. A second start pulse at cycle 10 is ignored, so no extra frame follows.
- abort at cycle 5 of a frame -> x_out=0 and busy=0 from the next edge; no done pulse. A new start afterwards sends the full 12-bit code from the MSB.
- RST pulse at cycle 7 mid-frame, with start held high during RST -> all outputs 0 after the reset edge and stay IDLE while RST=1. Start sampled after RST falls launches a clean frame.
